note_voice_allocator: RTL and testbench

- Schedules notes emitted by the song reader onto a bank of NUM_VOICES note players, so chords and overlapping notes sound together.
- Tracks each voice's remaining duration in beats and frees the voice when the duration expires.
- When every voice is busy, steals the voice with the fewest beats remaining.
- Sits between song_reader_new (new_note/note/duration) and the per-voice note_player instances.

---
 rtl/note_voice_allocator.sv | 147 ++++++++++++++
 tb/tb_note_voice_allocator.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/note_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : note_voice_allocator
//  Description : Schedules incoming notes onto a bank of NUM_VOICES note
//                players. Each voice keeps a remaining-beats counter. A voice
//                is freed when its counter expires. When every voice is busy,
//                the voice with the fewest beats left is stolen.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          : system clock
//    reset        : asynchronous active-high reset
//    beat         : one-cycle beat strobe
//    play         : 1 = duration counters run, 0 = counters freeze
//    new_note     : one-cycle request to schedule note/duration
//    note         : note code, valid with new_note
//    duration     : note length in beats, valid with new_note
//    voice_load   : one-hot pulse, voice i starts its held note
//    voice_note   : held note per voice, voice i at [i*NOTE_W +: NOTE_W]
//    voice_active : voice i currently sounding
//    steal        : pulse, the last load evicted an active voice
//    drop         : pulse, the last request had duration 0 and was discarded
//    active_count : number of active voices
// ============================================================================
module note_voice_allocator #(
  parameter int NUM_VOICES = 3,
  parameter int NOTE_W     = 6,
  parameter int DUR_W      = 6
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         beat,
  input  logic                         play,
  input  logic                         new_note,
  input  logic [NOTE_W-1:0]            note,
  input  logic [DUR_W-1:0]             duration,
  output logic [NUM_VOICES-1:0]        voice_load,
  output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
  output logic [NUM_VOICES-1:0]        voice_active,
  output logic                         steal,
  output logic                         drop,
  output logic [3:0]                   active_count
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  // Registered state
  logic [NUM_VOICES-1:0]        load_q,   load_d;
  logic [NUM_VOICES*NOTE_W-1:0] note_q,   note_d;
  logic [NUM_VOICES-1:0]        active_q, active_d;
  logic [DUR_W-1:0]             rem_q [NUM_VOICES];
  logic [DUR_W-1:0]             rem_d [NUM_VOICES];
  logic                         steal_q,  steal_d;
  logic                         drop_q,   drop_d;
  logic [3:0]                   count_q,  count_d;

  // Allocation helpers
  logic             any_idle;
  logic [IDX_W-1:0] idle_idx;
  logic [IDX_W-1:0] min_idx;
  logic [DUR_W-1:0] min_rem;
  logic [IDX_W-1:0] victim;
  logic             alloc_en;
  logic             tick;

  always_comb begin
    // Lowest-index idle voice: scan downward so the last hit is the lowest.
    any_idle = 1'b0;
    idle_idx = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (!active_q[i]) begin
        any_idle = 1'b1;
        idle_idx = IDX_W'(i);
      end
    end

    // Smallest remaining count. A strict compare keeps ties on the lowest index.
    min_idx = '0;
    min_rem = rem_q[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (rem_q[i] < min_rem) begin
        min_rem = rem_q[i];
        min_idx = IDX_W'(i);
      end
    end

    alloc_en = new_note && (duration != '0);
    victim   = any_idle ? idle_idx : min_idx;
    tick     = beat && play;
    steal_d  = alloc_en && !any_idle;
    drop_d   = new_note && (duration == '0);

    load_d   = '0;
    note_d   = note_q;
    active_d = active_q;
    count_d  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      rem_d[i] = rem_q[i];
      if (alloc_en && (victim == IDX_W'(i))) begin
        // A loaded voice takes the full duration and skips this beat.
        load_d[i]                  = 1'b1;
        note_d[i*NOTE_W +: NOTE_W] = note;
        rem_d[i]                   = duration;
        active_d[i]                = 1'b1;
      end else if (tick && active_q[i] && (rem_q[i] != '0)) begin
        rem_d[i] = rem_q[i] - DUR_W'(1);
        if (rem_q[i] == DUR_W'(1)) begin
          active_d[i] = 1'b0;
        end
      end
      count_d = count_d + 4'(active_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      load_q   <= '0;
      note_q   <= '0;
      active_q <= '0;
      steal_q  <= 1'b0;
      drop_q   <= 1'b0;
      count_q  <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        rem_q[i] <= '0;
      end
    end else begin
      load_q   <= load_d;
      note_q   <= note_d;
      active_q <= active_d;
      steal_q  <= steal_d;
      drop_q   <= drop_d;
      count_q  <= count_d;
      for (int i = 0; i < NUM_VOICES; i++) begin
        rem_q[i] <= rem_d[i];
      end
    end
  end

  assign voice_load   = load_q;
  assign voice_note   = note_q;
  assign voice_active = active_q;
  assign steal        = steal_q;
  assign drop         = drop_q;
  assign active_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_note_voice_allocator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_voice_allocator
//  Description : Directed self-checking bench for note_voice_allocator with
//                the default parameters (3 voices, 6-bit note, 6-bit duration).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_voice_allocator;

  logic        clk;
  logic        reset;
  logic        beat;
  logic        play;
  logic        new_note;
  logic [5:0]  note;
  logic [5:0]  duration;
  logic [2:0]  voice_load;
  logic [17:0] voice_note;
  logic [2:0]  voice_active;
  logic        steal;
  logic        drop;
  logic [3:0]  active_count;

  int total;
  int bad;

  note_voice_allocator #(
    .NUM_VOICES(3),
    .NOTE_W    (6),
    .DUR_W     (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .beat        (beat),
    .play        (play),
    .new_note    (new_note),
    .note        (note),
    .duration    (duration),
    .voice_load  (voice_load),
    .voice_note  (voice_note),
    .voice_active(voice_active),
    .steal       (steal),
    .drop        (drop),
    .active_count(active_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given strobes; outputs are stable 1 ns after it.
  task automatic step(input logic b, input logic nn, input logic [5:0] n, input logic [5:0] d);
    beat     = b;
    new_note = nn;
    note     = n;
    duration = d;
    @(posedge clk);
    #1;
    beat     = 1'b0;
    new_note = 1'b0;
  endtask

  task automatic beats(input int k);
    for (int i = 0; i < k; i++) step(1'b1, 1'b0, 6'd0, 6'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    beat     = 1'b0;
    play     = 1'b1;
    new_note = 1'b0;
    note     = '0;
    duration = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_active", 32'(voice_active), 32'h0);
    check_eq("rst_load",   32'(voice_load),   32'h0);
    check_eq("rst_note",   32'(voice_note),   32'h0);
    check_eq("rst_flags",  32'({steal, drop}), 32'h0);
    check_eq("rst_count",  32'(active_count), 32'h0);
    reset = 1'b0;
    step(1'b0, 1'b0, 6'd0, 6'd0);

    // Single note, 3 beats long
    step(1'b0, 1'b1, 6'd20, 6'd3);
    check_eq("t1_load",   32'(voice_load),      32'b001);
    check_eq("t1_note",   32'(voice_note[5:0]), 32'd20);
    check_eq("t1_count",  32'(active_count),    32'd1);
    step(1'b0, 1'b0, 6'd0, 6'd0);
    check_eq("t1_load_off", 32'(voice_load),    32'b000);
    beats(2);
    check_eq("t1_still_on", 32'(voice_active),  32'b001);
    beats(1);
    check_eq("t1_freed",  32'(voice_active),    32'b000);
    check_eq("t1_count0", 32'(active_count),    32'd0);
    check_eq("t1_note_hold", 32'(voice_note[5:0]), 32'd20);

    // Back-to-back notes fill all voices in index order
    step(1'b0, 1'b1, 6'd1, 6'd5);
    check_eq("t2_load0", 32'(voice_load), 32'b001);
    check_eq("t2_steal0", 32'(steal), 32'd0);
    step(1'b0, 1'b1, 6'd2, 6'd2);
    check_eq("t2_load1", 32'(voice_load), 32'b010);
    check_eq("t2_steal1", 32'(steal), 32'd0);
    step(1'b0, 1'b1, 6'd3, 6'd4);
    check_eq("t2_load2", 32'(voice_load), 32'b100);
    check_eq("t2_steal2", 32'(steal), 32'd0);
    check_eq("t2_count", 32'(active_count), 32'd3);

    // All busy, rem = 5,2,4: voice 1 is stolen
    step(1'b0, 1'b1, 6'd9, 6'd7);
    check_eq("t3_load",  32'(voice_load), 32'b010);
    check_eq("t3_steal", 32'(steal), 32'd1);
    check_eq("t3_note1", 32'(voice_note[11:6]), 32'd9);
    check_eq("t3_count", 32'(active_count), 32'd3);
    step(1'b0, 1'b0, 6'd0, 6'd0);
    check_eq("t3_steal_off", 32'(steal), 32'd0);
    // rem = 5,7,4
    beats(4);
    check_eq("t3_b4", 32'(voice_active), 32'b011);
    beats(1);
    check_eq("t3_b5", 32'(voice_active), 32'b010);
    beats(1);
    check_eq("t3_b6", 32'(voice_active), 32'b010);
    beats(1);
    check_eq("t3_b7", 32'(voice_active), 32'b000);

    // Build rem = 1,3,3 then beat together with a new note
    step(1'b0, 1'b1, 6'd4, 6'd2);
    step(1'b0, 1'b1, 6'd5, 6'd4);
    step(1'b0, 1'b1, 6'd6, 6'd4);
    beats(1);
    check_eq("t4_pre", 32'(voice_active), 32'b111);
    step(1'b1, 1'b1, 6'd33, 6'd5);
    check_eq("t4_load",   32'(voice_load), 32'b001);
    check_eq("t4_steal",  32'(steal), 32'd1);
    check_eq("t4_active", 32'(voice_active), 32'b111);
    check_eq("t4_note0",  32'(voice_note[5:0]), 32'd33);
    // rem = 5,2,2
    beats(1);
    check_eq("t4_b1", 32'(voice_active), 32'b111);
    beats(1);
    check_eq("t4_b2", 32'(voice_active), 32'b001);
    check_eq("t4_count", 32'(active_count), 32'd1);

    // voice 0 rem = 3 -> 2, then freeze
    beats(1);
    play = 1'b0;
    beats(5);
    check_eq("t5_frozen", 32'(voice_active), 32'b001);
    play = 1'b1;
    beats(1);
    check_eq("t5_b1", 32'(voice_active), 32'b001);
    beats(1);
    check_eq("t5_b2", 32'(voice_active), 32'b000);

    // Notes are still accepted while play is low
    play = 1'b0;
    step(1'b1, 1'b1, 6'd44, 6'd10);
    check_eq("t6_load_paused", 32'(voice_load), 32'b001);
    play = 1'b1;
    // Zero-duration request is dropped
    step(1'b0, 1'b1, 6'd50, 6'd0);
    check_eq("t6_drop",   32'(drop), 32'd1);
    check_eq("t6_load",   32'(voice_load), 32'b000);
    check_eq("t6_active", 32'(voice_active), 32'b001);
    check_eq("t6_note",   32'(voice_note[5:0]), 32'd44);
    check_eq("t6_steal",  32'(steal), 32'd0);
    step(1'b0, 1'b0, 6'd0, 6'd0);
    check_eq("t6_drop_off", 32'(drop), 32'd0);

    // Asynchronous reset mid-note, checked before any clock edge
    step(1'b0, 1'b1, 6'd7, 6'd9);
    check_eq("t7_pre_load", 32'(voice_load), 32'b010);
    reset = 1'b1;
    #2;
    check_eq("t7_active", 32'(voice_active), 32'h0);
    check_eq("t7_load",   32'(voice_load), 32'h0);
    check_eq("t7_note",   32'(voice_note), 32'h0);
    check_eq("t7_count",  32'(active_count), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
